fg_scanout: RTL

- Downstream video-side consumer of the foreground dual-port VRAM.
- At each horizontal blank, it requests the VRAM bus and issues a memory-to-register read transfer for the next scanline's row.
- During active video, it clocks the serial port (SC) and buffers SQ bytes in a 4-entry FIFO, popping one 8-bit pixel index per pixel clock enable.
- Sits between the VRAM and the foreground palette/mixer stage; the CPU shares the VRAM bus through an external arbiter (REQ/GNT).

---
 rtl/fg_scanout.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/fg_scanout.sv
// Foreground VRAM scan-out: per-line read transfer at HBLANK, then serial-port fetch into a
// 4-deep pixel FIFO that is drained one index per CE_PIX; UNDERFLOW latches any empty pop.
module fg_scanout #(
    parameter int H_ACTIVE = 256,
    parameter int SQ_LAT   = 3,
    parameter int SC_HALF  = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE_PIX,
    input  logic        HBLANK,
    input  logic        VBLANK,
    input  logic [8:0]  VCNT,
    input  logic [7:0]  SCROLL_X,
    input  logic [7:0]  SCROLL_Y,
    output logic        BUS_REQ,
    input  logic        BUS_GNT,
    output logic [15:0] VA,
    output logic        RAS_N,
    output logic [1:0]  CAS_N,
    output logic        WE_N,
    output logic        OE_N,
    input  logic        RDY,
    output logic        SC,
    output logic        SE_N,
    input  logic [7:0]  SQ,
    output logic [7:0]  PIX,
    output logic        PIX_VALID,
    output logic        UNDERFLOW
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_SETUP, S_STROBE, S_RELEASE, S_STREAM
    } state_t;

    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_HIGH = 2'd1;
    localparam logic [1:0] PH_LOW  = 2'd2;

    state_t      r_state, w_next;
    logic        r_hblank_d;
    logic [7:0]  r_row, r_col;
    logic [15:0] r_va;
    logic [1:0]  r_guard;
    logic [7:0]  r_lat;
    logic        r_sc;
    logic [1:0]  r_sc_ph;
    logic [7:0]  r_sc_cnt;
    logic [7:0]  r_mem [4];
    logic [1:0]  r_wr, r_rd;
    logic [2:0]  r_cnt;
    logic [8:0]  r_push_cnt, r_pop_cnt;
    logic [7:0]  r_pix;
    logic        r_pix_vld;
    logic        r_underflow;

    logic w_trig, w_pop_req, w_pop, w_push;
    logic w_bus_req, w_ras_n, w_oe_n;
    logic w_unused;

    assign w_unused = VCNT[8];

    assign w_trig    = HBLANK & ~r_hblank_d & ~VBLANK &
                       ((r_state == S_IDLE) || (r_state == S_STREAM));
    assign w_pop_req = CE_PIX & ~HBLANK & ~VBLANK & (r_pop_cnt < 9'(H_ACTIVE));
    assign w_pop     = w_pop_req & (r_cnt != 3'd0);
    // A full FIFO still accepts a byte when the same cycle pops one.
    assign w_push    = (r_state == S_STREAM) & ~w_trig & (r_sc_ph == PH_IDLE) &
                       (r_lat == 8'd0) & (r_push_cnt < 9'(H_ACTIVE)) &
                       ((r_cnt != 3'd4) | w_pop);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_bus_req = 1'b0;
        w_ras_n   = 1'b1;
        w_oe_n    = 1'b1;
        case (r_state)
            S_IDLE:    if (w_trig) w_next = S_REQ;
            S_REQ: begin
                w_bus_req = 1'b1;
                if (BUS_GNT) w_next = S_SETUP;
            end
            S_SETUP: begin
                w_bus_req = 1'b1;
                w_oe_n    = 1'b0;
                w_next    = S_STROBE;
            end
            S_STROBE: begin
                w_bus_req = 1'b1;
                w_ras_n   = 1'b0;
                w_oe_n    = 1'b0;
                // RDY may still show the previous completion for two cycles.
                if (r_guard == 2'd2 && RDY) w_next = S_RELEASE;
            end
            S_RELEASE: w_next = S_STREAM;
            S_STREAM:  if (w_trig) w_next = S_REQ;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_hblank_d <= 1'b0;
            r_row      <= 8'd0;
            r_col      <= 8'd0;
            r_va       <= 16'd0;
            r_guard    <= 2'd0;
            r_lat      <= 8'd0;
        end else begin
            r_hblank_d <= HBLANK;
            if (w_trig) begin
                r_row <= VCNT[7:0] + 8'd1 + SCROLL_Y;
                r_col <= SCROLL_X;
            end
            if (r_state == S_REQ && BUS_GNT) r_va <= {r_row, r_col};
            if (r_state == S_SETUP)                           r_guard <= 2'd0;
            else if (r_state == S_STROBE && r_guard != 2'd2)  r_guard <= r_guard + 2'd1;
            if (r_state == S_RELEASE || w_push) r_lat <= 8'(SQ_LAT);
            else if (r_lat != 8'd0)             r_lat <= r_lat - 8'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sc     <= 1'b0;
            r_sc_ph  <= PH_IDLE;
            r_sc_cnt <= 8'd0;
        end else if (w_trig || r_state != S_STREAM) begin
            r_sc     <= 1'b0;
            r_sc_ph  <= PH_IDLE;
            r_sc_cnt <= 8'd0;
        end else begin
            case (r_sc_ph)
                PH_IDLE: if (w_push) begin
                    r_sc     <= 1'b1;
                    r_sc_ph  <= PH_HIGH;
                    r_sc_cnt <= 8'd0;
                end
                PH_HIGH: if (r_sc_cnt == 8'(SC_HALF - 1)) begin
                    r_sc     <= 1'b0;
                    r_sc_ph  <= PH_LOW;
                    r_sc_cnt <= 8'd0;
                end else begin
                    r_sc_cnt <= r_sc_cnt + 8'd1;
                end
                // The idle (push) cycle is the last low cycle of the SC period.
                PH_LOW: if (r_sc_cnt >= 8'(SC_HALF - 2)) r_sc_ph <= PH_IDLE;
                        else                             r_sc_cnt <= r_sc_cnt + 8'd1;
                default: r_sc_ph <= PH_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wr] <= SQ;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr        <= 2'd0;
            r_rd        <= 2'd0;
            r_cnt       <= 3'd0;
            r_push_cnt  <= 9'd0;
            r_pop_cnt   <= 9'd0;
            r_pix       <= 8'd0;
            r_pix_vld   <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_pix_vld <= w_pop_req;
            if (w_trig) begin
                r_wr       <= 2'd0;
                r_rd       <= 2'd0;
                r_cnt      <= 3'd0;
                r_push_cnt <= 9'd0;
                r_pop_cnt  <= 9'd0;
            end else begin
                if (w_push) begin
                    r_wr       <= r_wr + 2'd1;
                    r_push_cnt <= r_push_cnt + 9'd1;
                end
                if (w_pop) r_rd <= r_rd + 2'd1;
                r_cnt <= r_cnt + {2'b00, w_push} - {2'b00, w_pop};
                if (w_pop_req) begin
                    r_pop_cnt <= r_pop_cnt + 9'd1;
                    r_pix     <= w_pop ? r_mem[r_rd] : 8'd0;
                    if (!w_pop) r_underflow <= 1'b1;
                end
            end
        end
    end

    assign BUS_REQ   = w_bus_req;
    assign RAS_N     = w_ras_n;
    assign OE_N      = w_oe_n;
    assign VA        = r_va;
    assign CAS_N     = 2'b11;
    assign WE_N      = 1'b1;
    assign SE_N      = 1'b0;
    assign SC        = r_sc;
    assign PIX       = r_pix;
    assign PIX_VALID = r_pix_vld;
    assign UNDERFLOW = r_underflow;

endmodule
